// File: rtl/queue_serializer_if.sv
// queue_serializer_if: groups the queue-side and serial-side signals of queue_serializer.
//   len_in          queue occupancy, 0..8
//   data_in         byte presented by the queue
//   tx_enable_in    downstream allows a new byte to start
//   dequeue_out     one-cycle remove request to the queue
//   serial_out      current serial bit (0 when write_out is low)
//   write_out       serial_out carries a valid bit this cycle
//   busy_out        a byte transfer is in progress
//   frame_count_out completed-byte count, wraps modulo 256
// Modports: master drives the queue/enable side, slave is the serializer itself.
interface queue_serializer_if;
  logic [3:0] len_in;
  logic [7:0] data_in;
  logic       tx_enable_in;
  logic       dequeue_out;
  logic       serial_out;
  logic       write_out;
  logic       busy_out;
  logic [7:0] frame_count_out;

  modport master (
    output len_in, data_in, tx_enable_in,
    input  dequeue_out, serial_out, write_out, busy_out, frame_count_out
  );

  modport slave (
    input  len_in, data_in, tx_enable_in,
    output dequeue_out, serial_out, write_out, busy_out, frame_count_out
  );
endinterface

// File: rtl/queue_serializer.sv
// queue_serializer: pulls one byte at a time from a queue and shifts it out serially.
// Ports:
//   clk_10khz  rising-edge clock shared with the queue
//   reset      asynchronous, active-low reset
//   qs         queue_serializer_if.slave (queue handshake, serial output, status)
// Parameters:
//   MSB_FIRST  1 = bit 7 first, 0 = bit 0 first
//   DEQ_WAIT   cycles (1..7) spent waiting between dequeue_out and capturing data_in
// Sequence per byte: IDLE -> DEQ (1) -> WAIT (DEQ_WAIT) -> LOAD (1) -> SHIFT (8) -> GAP (1).
// All outputs are decoded from registered state only.
module queue_serializer #(
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned DEQ_WAIT  = 2
) (
  input logic               clk_10khz,
  input logic               reset,
  queue_serializer_if.slave qs
);

  typedef enum logic [2:0] {
    StIdle,
    StDeq,
    StWait,
    StLoad,
    StShift,
    StGap
  } state_e;

  localparam logic [2:0] WaitLast = 3'(DEQ_WAIT - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;     // WAIT length counter, then SHIFT bit index
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] frame_q, frame_d;
  logic       cur_bit;

  always_ff @(posedge clk_10khz or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    unique case (state_q)
      StIdle: begin
        if (qs.tx_enable_in && (qs.len_in != 4'd0)) begin
          state_d = StDeq;
        end
      end
      StDeq: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = '0;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StLoad: begin
        // Byte is latched once here; later queue activity cannot alter it.
        shreg_d = qs.data_in;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StGap;
        end
      end
      StGap: begin
        frame_d = frame_q + 8'd1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cur_bit = MSB_FIRST ? shreg_q[3'd7 - cnt_q] : shreg_q[cnt_q];

  assign qs.dequeue_out     = (state_q == StDeq);
  assign qs.write_out       = (state_q == StShift);
  assign qs.serial_out      = (state_q == StShift) & cur_bit;
  assign qs.busy_out        = (state_q != StIdle);
  assign qs.frame_count_out = frame_q;

endmodule

// File: doc/queue_serializer.md
QUEUE_SERIALIZER -- requirements
Module: queue_serializer

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock is clk_10khz and the reset is reset, which is asynchronous and active-low.
REQ-002 Parameter MSB_FIRST, default 1: bit order on serial_out (1 = bit 7 first, 0 = bit 0 first).
REQ-003 Parameter DEQ_WAIT, default 2, legal range 1..7: WAIT-state cycles between dequeue_out and the data_in capture.
REQ-004 clk_10khz  input  1  rising-edge clock shared with the queue.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 len_in  input  4  queue occupancy, 0..8.
REQ-007 data_in  input  8  queue data output byte.
REQ-008 tx_enable_in  input  1  downstream permits start of a new byte.
REQ-009 dequeue_out  output  1  one-cycle remove request to the queue.
REQ-010 serial_out  output  1  current serial bit.
REQ-011 write_out  output  1  serial_out is a valid bit this cycle.
REQ-012 busy_out  output  1  a byte transfer is in progress.
REQ-013 frame_count_out  output  8  count of completed bytes, wraps modulo 256.

Function
REQ-014 The FSM SHALL have states IDLE, DEQ, WAIT, LOAD, SHIFT and GAP; all outputs are registered or decoded from registered state only.
REQ-015 IDLE -> DEQ SHALL occur when tx_enable_in=1 and len_in!=0 at a rising edge; otherwise the FSM stays in IDLE.
REQ-016 DEQ SHALL last exactly 1 cycle with dequeue_out=1, then go to WAIT; dequeue_out SHALL be 0 in every other state.
REQ-017 WAIT SHALL last exactly DEQ_WAIT cycles, then go to LOAD.
REQ-018 LOAD SHALL last 1 cycle, capture data_in into an 8-bit shift register, clear the bit counter, then go to SHIFT.
REQ-019 SHIFT SHALL last exactly 8 cycles with write_out=1, presenting one bit per cycle in MSB_FIRST order via a 3-bit counter 0..7.
REQ-020 After the 8th bit, the FSM SHALL enter GAP for 1 cycle with write_out=0, increment frame_count_out by 1 (255 -> 0), then return to IDLE.
REQ-021 serial_out SHALL be 0 whenever write_out=0.
REQ-022 busy_out SHALL be 1 in every state except IDLE.
REQ-023 Latency (DEQ_WAIT=2): with the start condition at edge 0, dequeue_out SHALL be high in cycle 1, the first bit in cycle 5, the last bit in cycle 12, GAP in cycle 13, and IDLE in cycle 14 (generally, the first bit is in cycle DEQ_WAIT+3).
REQ-024 Once DEQ is entered the transfer SHALL complete: deassertion of tx_enable_in, or len_in becoming 0, during DEQ/WAIT/LOAD/SHIFT SHALL neither abort the transfer nor alter the byte.
REQ-025 Back-to-back: if the start condition holds in the IDLE cycle after GAP, the next DEQ SHALL follow immediately, giving at least 2 idle-bit cycles (GAP + IDLE) between bytes.
REQ-026 No more than one dequeue_out pulse SHALL be issued per transmitted byte; no pulse SHALL be issued when len_in=0 in IDLE.

Reset
REQ-027 reset=0 SHALL immediately force: state IDLE, dequeue_out=0, serial_out=0, write_out=0, busy_out=0, frame_count_out=0x00, shift register and counters 0.
REQ-028 Reset asserted mid-transfer SHALL discard the partial byte, SHALL NOT increment frame_count_out, and SHALL NOT cause a resend.
REQ-029 After reset is released, the first start condition SHALL be evaluated at the first rising edge with reset=1.

Verification
REQ-030 len_in=1, data_in=0xA5, tx_enable_in=1, defaults -> dequeue_out high in cycle 1 only; serial_out 1,0,1,0,0,1,0,1 in cycles 5..12 with write_out=1; frame_count_out=1 after cycle 13.
REQ-031 MSB_FIRST=0, data_in=0x01 -> serial_out 1,0,0,0,0,0,0,0 in the SHIFT cycles.
REQ-032 len_in=3, enable held high, bytes 0x11/0x22/0x33 -> exactly 3 dequeue pulses spaced 14 cycles apart, and frame_count_out=3.
REQ-033 len_in=0 with enable high for 50 cycles -> no dequeue_out pulse, and busy_out=0 throughout.
REQ-034 tx_enable_in dropped at SHIFT bit 3 -> byte completes; the FSM then stays in IDLE despite len_in>0.
REQ-035 reset pulsed low at SHIFT bit 4 -> all outputs 0 within the same cycle, frame_count_out=0, and no resend after release unless a new start condition occurs.
